// File: rtl/lb_uart_rx_datapath_if.sv
// Bus bundle between the UART Rx control unit / host and the Rx datapath.
//   master : drives line/control strobes and FIFO pop, observes FIFO head.
//   slave  : the datapath; receives strobes, presents head entry and status.
// Signals: bit8, parity_en, rx, shift, done, rd, clr_ovr (master -> slave);
//          rx_data, parity_err, frame_err, rx_ready, fifo_count, overrun
//          (slave -> master).
interface lb_uart_rx_datapath_if #(
  parameter int unsigned ADDR_W = 2
);
  logic              bit8;
  logic              parity_en;
  logic              rx;
  logic              shift;
  logic              done;
  logic              rd;
  logic              clr_ovr;
  logic [7:0]        rx_data;
  logic              parity_err;
  logic              frame_err;
  logic              rx_ready;
  logic [ADDR_W:0]   fifo_count;
  logic              overrun;

  modport master (
    output bit8, parity_en, rx, shift, done, rd, clr_ovr,
    input  rx_data, parity_err, frame_err, rx_ready, fifo_count, overrun
  );

  modport slave (
    input  bit8, parity_en, rx, shift, done, rd, clr_ovr,
    output rx_data, parity_err, frame_err, rx_ready, fifo_count, overrun
  );
endinterface

// File: rtl/lb_uart_rx_datapath.sv
// UART receive datapath: captures serial bits into a frame register on each
// shift strobe, assembles {frame_err, parity_err, data} on done and pushes it
// into a small show-ahead FIFO with a sticky overrun flag.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : lb_uart_rx_datapath_if.slave (control strobes in, FIFO head out)
module lb_uart_rx_datapath #(
  parameter int unsigned ADDR_W     = 2,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  lb_uart_rx_datapath_if.slave   bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned IDX_MAX = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = DATA_W + 2;

  logic [FRAME_W-1:0] frame;
  logic [IDX_W-1:0]   idx;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overrun;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0]  data_c;
  logic               pbit_c;
  logic               stop_c;
  logic               perr_c;
  logic               full_c;
  logic               empty_c;
  logic               pop_c;
  logic               push_c;
  logic               ovr_set_c;

  // Frame assembly: stop bit position depends on data width and parity.
  always_comb begin
    data_c = bus.bit8 ? frame[7:0] : {1'b0, frame[6:0]};
    pbit_c = bus.bit8 ? frame[8] : frame[7];
    stop_c = 1'b0;
    case ({bus.bit8, bus.parity_en})
      2'b11:   stop_c = frame[9];
      2'b10:   stop_c = frame[8];
      2'b01:   stop_c = frame[8];
      default: stop_c = frame[7];
    endcase
    perr_c = bus.parity_en & ((^data_c ^ pbit_c) != ODD_PARITY);
  end

  // FIFO control: a pop frees room for a same-cycle push when full.
  always_comb begin
    full_c    = (count == CNT_W'(DEPTH));
    empty_c   = (count == '0);
    pop_c     = bus.rd & ~empty_c;
    push_c    = bus.done & (~full_c | pop_c);
    ovr_set_c = bus.done & full_c & ~pop_c;
  end

  // Bit capture; index saturates so stray shifts cannot corrupt the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      idx   <= '0;
    end else if (bus.done) begin
      idx <= '0;
    end else if (bus.shift && (idx != IDX_W'(IDX_MAX))) begin
      for (int unsigned i = 0; i < FRAME_W; i++) begin
        if (idx == IDX_W'(i)) frame[i] <= bus.rx;
      end
      idx <= idx + IDX_W'(1);
    end
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovr_set_c)        overrun <= 1'b1;
      else if (bus.clr_ovr) overrun <= 1'b0;
    end
  end

  // Storage; only the post-reset head slot is zeroed so outputs start clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= {~stop_c, perr_c, data_c};
    end
  end

  // Show-ahead head entry and status, all from registered state.
  assign bus.rx_data    = mem[rd_ptr][DATA_W-1:0];
  assign bus.parity_err = mem[rd_ptr][DATA_W];
  assign bus.frame_err  = mem[rd_ptr][DATA_W+1];
  assign bus.rx_ready   = ~empty_c;
  assign bus.fifo_count = count;
  assign bus.overrun    = overrun;

endmodule
